// File: rtl/counter_pkg.sv
// counter_pkg: direction constants, WIDTH legal range and load clamp shared by the counter slice
package counter_pkg;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    function automatic logic [WIDTH_MAX-1:0] clamp_load(input logic [WIDTH_MAX-1:0] val, input logic [WIDTH_MAX-1:0] max);
        return (val > max) ? max : val;
    endfunction
endpackage

// File: rtl/bin2gray.sv
// bin2gray: combinational binary to Gray code conversion
module bin2gray #(parameter int WIDTH = 4) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with load, wrap/saturate, tc and wrap pulse; registered gray output under GRAY_OUT_EN
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
`ifdef GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || MAX_VAL < 64'd1 || MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_params
        $error("updown_mod_counter: illegal WIDTH/MAX_VAL");
    end
    logic [WIDTH-1:0] nxt;
    logic at_max, at_zero, lim, wrap_nxt;
    assign at_max = count == MAXV;
    assign at_zero = count == '0;
    assign lim = (up == DIR_UP) ? at_max : at_zero;
    assign tc = lim;
    always_comb begin
        wrap_nxt = en & ~load & lim & ~SATURATE;
        nxt = load ? WIDTH'(clamp_load(WIDTH_MAX'(load_val), WIDTH_MAX'(MAXV)))
            : ~en ? count
            : lim ? (SATURATE ? count : (up ? '0 : MAXV))
            : up ? count + 1'b1 : count - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap <= 1'b0;
        end else begin
            count <= nxt;
            wrap <= wrap_nxt;
        end
    end
`ifdef GRAY_OUT_EN
    logic [WIDTH-1:0] gray_nxt;
    bin2gray #(.WIDTH(WIDTH)) u_b2g (.bin(nxt), .gray(gray_nxt));
    always_ff @(posedge clk) begin
        if (reset) gray <= '0;
        else gray <= gray_nxt;
    end
`endif
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: randomized and directed check of three counter configurations against a reference model
module tb_updown_mod_counter;
    localparam int N = 3;
    localparam int MX [N] = '{9, 9, 15};
    localparam bit SAT [N] = '{1'b0, 1'b1, 1'b0};
    logic clk = 1'b0;
    logic reset = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] cnt [N];
    logic tcv [N];
    logic wrv [N];
`ifdef GRAY_OUT_EN
    logic [3:0] gry [N];
`endif
    int mc [N];
    int mw [N];
    int nvec = 0;
    int nerr = 0;
    always #5 clk = ~clk;
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(cnt[0]), .tc(tcv[0]), .wrap(wrv[0])
`ifdef GRAY_OUT_EN
        , .gray(gry[0])
`endif
    );
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(cnt[1]), .tc(tcv[1]), .wrap(wrv[1])
`ifdef GRAY_OUT_EN
        , .gray(gry[1])
`endif
    );
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) u2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(cnt[2]), .tc(tcv[2]), .wrap(wrv[2])
`ifdef GRAY_OUT_EN
        , .gray(gry[2])
`endif
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("count%0d", i), 32'(cnt[i]), mc[i]);
            chk($sformatf("wrap%0d", i), 32'(wrv[i]), mw[i]);
            chk($sformatf("tc%0d", i), 32'(tcv[i]), 32'(up ? mc[i] == MX[i] : mc[i] == 0));
`ifdef GRAY_OUT_EN
            chk($sformatf("gray%0d", i), 32'(gry[i]), mc[i] ^ (mc[i] >> 1));
`endif
        end
    endtask
    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            mw[i] = 0;
            if (reset) mc[i] = 0;
            else if (load) mc[i] = (int'(load_val) > MX[i]) ? MX[i] : int'(load_val);
            else if (en && up) begin
                if (mc[i] < MX[i]) mc[i]++;
                else if (!SAT[i]) begin mc[i] = 0; mw[i] = 1; end
            end else if (en) begin
                if (mc[i] > 0) mc[i]--;
                else if (!SAT[i]) begin mc[i] = MX[i]; mw[i] = 1; end
            end
        end
        #1;
        check_all();
    endtask
    task automatic drive(input logic r, input logic l, input logic e, input logic u, input int v, input int n);
        reset = r; load = l; en = e; up = u; load_val = 4'(v);
        for (int k = 0; k < n; k++) cycle();
    endtask
    initial begin
        for (int i = 0; i < N; i++) begin mc[i] = 0; mw[i] = 0; end
        drive(1, 0, 0, 0, 0, 2);
        chk("reset_tc_down", 32'(tcv[0]), 1);
        drive(0, 0, 1, 1, 0, 12);
        drive(1, 0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 0, 3);
        drive(0, 1, 0, 1, 13, 1);
        chk("load_clamp", 32'(cnt[0]), 9);
        chk("load_clamp_nowrap", 32'(wrv[0]), 0);
        drive(0, 1, 1, 1, 4, 1);
        chk("load_beats_en", 32'(cnt[0]), 4);
        drive(0, 0, 1, 1, 0, 8);
        drive(0, 0, 1, 0, 0, 12);
        drive(0, 1, 0, 1, 6, 1);
        drive(1, 0, 1, 1, 0, 1);
        chk("reset_mid_count", 32'(cnt[0]), 0);
        drive(0, 1, 0, 1, 5, 1);
        drive(0, 0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        chk("dir_toggle", 32'(cnt[0]), 5);
        drive(0, 1, 0, 1, 0, 1);
        drive(0, 0, 1, 1, 0, 17);
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) up = ~up;
            load_val = 4'($urandom_range(0, 15));
            #1;
            for (int i = 0; i < N; i++)
                chk($sformatf("tc_comb%0d", i), 32'(tcv[i]), 32'(up ? mc[i] == MX[i] : mc[i] == 0));
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
